// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU pipe and a FIFO-buffered load unit
// into the single regfile write port, and exports a pending-write mask.
module wb_arbiter #(
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        wEn,
  output logic [4:0]  write_sel,
  output logic [31:0] write_data,
  output logic [31:0] busy_mask
);

  localparam int PW   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] LAST_CNT = SW'(STARVE_LIMIT - 1);

  typedef enum logic {
    NORMAL,
    STARVE
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LQ_DEPTH-1:0] vld_q, vld_d;
  logic [4:0]        ent_rd_q [LQ_DEPTH];
  logic [31:0]       ent_data_q [LQ_DEPTH];
  logic              wen_q, wen_d;
  logic [4:0]        sel_q, sel_d;
  logic [31:0]       data_q, data_d;

  logic fifo_full;
  logic fifo_ne;
  logic alu_claim;
  logic load_grant;
  logic alu_fire;
  logic alu_wr;
  logic push;
  logic pop;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_ne    = (count_q != '0);
  assign alu_claim  = alu_valid && (alu_rd != 5'd0);
  assign load_grant = reset && fifo_ne &&
                      ((state_q == STARVE) || !alu_claim);
  assign ld_ready   = reset && !fifo_full;
  assign alu_ready  = reset && !((state_q == STARVE) && fifo_ne);
  assign alu_fire   = alu_valid && alu_ready;
  assign alu_wr     = alu_fire && (alu_rd != 5'd0);
  assign push       = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign pop        = load_grant;

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    if (pop) begin
      rd_ptr_d        = rd_ptr_q + PW'(1);
      vld_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d        = wr_ptr_q + PW'(1);
      vld_d[wr_ptr_q] = 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A load grant and an ALU write are mutually exclusive by construction
  always_comb begin
    wen_d  = 1'b0;
    sel_d  = sel_q;
    data_d = data_q;
    unique case (1'b1)
      pop: begin
        wen_d  = 1'b1;
        sel_d  = ent_rd_q[rd_ptr_q];
        data_d = ent_data_q[rd_ptr_q];
      end
      alu_wr: begin
        wen_d  = 1'b1;
        sel_d  = alu_rd;
        data_d = alu_data;
      end
      default: begin
        wen_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      NORMAL: begin
        if (fifo_ne && !load_grant) begin
          if (scnt_q == LAST_CNT) begin
            state_d = STARVE;
            scnt_d  = '0;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end else begin
          scnt_d = '0;
        end
      end
      STARVE: begin
        scnt_d = '0;
        if (pop || !fifo_ne) begin
          state_d = NORMAL;
        end
      end
      default: begin
        state_d = NORMAL;
        scnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= NORMAL;
      scnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      wen_q    <= 1'b0;
      sel_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      wen_q    <= wen_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
    end
  end

  // Entry payload needs no reset: vld_q gates every use
  always_ff @(posedge clock) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= ld_rd;
      ent_data_q[wr_ptr_q] <= ld_data;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (vld_q[i]) begin
        busy_mask[ent_rd_q[i]] = 1'b1;
      end
    end
    if (wen_q) begin
      busy_mask[sel_q] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  assign wEn        = wen_q;
  assign write_sel  = sel_q;
  assign write_data = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then constrained-random
// traffic, all checked against a queue-based reference model.
module tb_wb_arbiter;

  localparam int LQ_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wEn;
  logic [4:0]  write_sel;
  logic [31:0] write_data;
  logic [31:0] busy_mask;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(
    .LQ_DEPTH    (LQ_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .wEn       (wEn),
    .write_sel (write_sel),
    .write_data(write_data),
    .busy_mask (busy_mask)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          m_starve;
  int          m_lose;
  logic        m_wen;
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  bit          alu_acc;
  bit          ld_acc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    foreach (q[i]) b[q[i].rd] = 1'b1;
    if (m_wen) b[m_sel] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // One clock: check handshake/mask before the edge, outputs after it
  task automatic tick();
    logic e_ar, e_lr, grant, rst;
    logic av, lv;
    logic [4:0] ar, lr;
    logic [31:0] ad, ldd;
    ent_t h;
    #1;
    e_lr  = reset && (q.size() < LQ_DEPTH);
    e_ar  = reset && !(m_starve && q.size() != 0);
    grant = reset && q.size() != 0 &&
            (m_starve || !(alu_valid && alu_rd != 0));
    chk("alu_ready", 32'(alu_ready), 32'(e_ar));
    chk("ld_ready", 32'(ld_ready), 32'(e_lr));
    chk("busy_mask", busy_mask, m_busy());
    rst = reset; av = alu_valid; ar = alu_rd; ad = alu_data;
    lv = ld_valid; lr = ld_rd; ldd = ld_data;
    alu_acc = av && e_ar;
    ld_acc  = lv && e_lr;
    @(posedge clock);
    if (!rst) begin
      q.delete();
      m_starve = 0; m_lose = 0;
      m_wen = 0; m_sel = '0; m_data = '0;
    end else begin
      if (grant) begin
        h = q.pop_front();
        m_wen = 1; m_sel = h.rd; m_data = h.data;
      end else if (alu_acc && ar != 0) begin
        m_wen = 1; m_sel = ar; m_data = ad;
      end else begin
        m_wen = 0;
      end
      if (m_starve) begin
        m_starve = 0; m_lose = 0;
      end else if ((q.size() + (grant ? 1 : 0)) != 0 && !grant) begin
        m_lose++;
        if (m_lose == STARVE_LIMIT) begin
          m_starve = 1; m_lose = 0;
        end
      end else begin
        m_lose = 0;
      end
      if (ld_acc && lr != 0) q.push_back('{rd: lr, data: ldd});
    end
    #1;
    chk("wEn", 32'(wEn), 32'(m_wen));
    chk("write_sel", 32'(write_sel), 32'(m_sel));
    chk("write_data", write_data, m_data);
  endtask

  initial begin
    reset = 0;
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1111;
    ld_valid = 1; ld_rd = 6; ld_data = 32'h2222;
    m_starve = 0; m_lose = 0;
    m_wen = 0; m_sel = '0; m_data = '0;

    // Reset with both producers valid
    tick();
    tick();
    chk("rst_wen", 32'(wEn), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_alu_rdy", 32'(alu_ready), 32'd0);
    chk("rst_ld_rdy", 32'(ld_ready), 32'd0);
    reset = 1; alu_valid = 0; ld_valid = 0;
    tick();
    chk("post_rst_wen", 32'(wEn), 32'd0);
    chk("post_rst_ld_rdy", 32'(ld_ready), 32'd1);

    // ALU path
    alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    chk("alu_wen", 32'(wEn), 32'd1);
    chk("alu_sel", 32'(write_sel), 32'd3);
    chk("alu_data", write_data, 32'hDEADBEEF);
    alu_valid = 1; alu_rd = 0; alu_data = 32'h5555;
    tick();
    alu_valid = 0;
    chk("alu_x0_wen", 32'(wEn), 32'd0);

    // Load path with idle ALU
    ld_valid = 1; ld_rd = 7; ld_data = 32'h42;
    tick();
    ld_valid = 0;
    chk("ld_wait_wen", 32'(wEn), 32'd0);
    chk("ld_busy7", 32'(busy_mask[7]), 32'd1);
    tick();
    chk("ld_wen", 32'(wEn), 32'd1);
    chk("ld_sel", 32'(write_sel), 32'd7);
    chk("ld_data", write_data, 32'h42);
    tick();
    chk("ld_busy7_clr", 32'(busy_mask[7]), 32'd0);

    // FIFO full while ALU writes x1
    alu_valid = 1; alu_rd = 1; alu_data = 32'hAA;
    ld_valid = 1; ld_rd = 8; ld_data = 32'h80;
    tick();
    ld_rd = 9; ld_data = 32'h90;
    tick();
    ld_rd = 10; ld_data = 32'hA0;
    #1;
    chk("full_ld_rdy", 32'(ld_ready), 32'd0);
    tick();
    alu_valid = 0;
    tick();
    chk("drain_sel8", 32'(write_sel), 32'd8);
    tick();
    ld_valid = 0;
    chk("drain_sel9", 32'(write_sel), 32'd9);
    tick();
    chk("drain_sel10", 32'(write_sel), 32'd10);
    tick();

    // Starvation
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    ld_valid = 1; ld_rd = 10; ld_data = 32'hA0;
    tick();
    ld_valid = 0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      tick();
      chk("starve_lose_sel", 32'(write_sel), 32'd1);
    end
    chk("starve_alu_rdy", 32'(alu_ready), 32'd0);
    tick();
    chk("starve_sel", 32'(write_sel), 32'd10);
    chk("starve_data", write_data, 32'hA0);
    tick();
    chk("resume_sel", 32'(write_sel), 32'd1);
    chk("resume_wen", 32'(wEn), 32'd1);

    // Reset mid-operation with two queued loads
    ld_valid = 1; ld_rd = 11; ld_data = 32'hB0;
    tick();
    ld_rd = 12; ld_data = 32'hC0;
    tick();
    ld_valid = 0; alu_valid = 0;
    reset = 0;
    tick();
    reset = 1;
    chk("midrst_busy", busy_mask, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_wr", 32'(wEn), 32'd0);
    end

    // Random traffic, producers hold until accepted
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) != 0);
      if (!alu_valid || alu_acc) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!ld_valid || ld_acc) begin
        ld_valid = ($urandom_range(0, 2) != 0);
        ld_rd    = 5'($urandom_range(0, 15));
        ld_data  = $urandom;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
